mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one memory-peripheral port (request address, count, write data, write enable; one-cycle registered response data and code) between the instruction-fetch master (m0) and the data-access master (m1). It sits between the core and a single peripheral such as the register/RAM blocks. It grants one request per cycle using round-robin with a configurable burst allowance, tracks which master owns the in-flight access, and routes the peripheral's response back only to that master.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one memory-peripheral port: round-robin grants with a
// burst allowance, plus routing of the one-cycle registered response to its owner.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_READ
`define MEM_CODE_READ 3'd0
`endif
`ifndef MEM_CODE_WRITE
`define MEM_CODE_WRITE 3'd1
`endif
`ifndef MEM_CODE_MISALIGNED
`define MEM_CODE_MISALIGNED 3'd2
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd7
`endif

module mem_port_arbiter #(
  parameter int BURST_LEN = 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [`ADDR_W-1:0]      i_m0_req_addr,
  input  logic [`MEM_COUNT_W-1:0] i_m0_req_count,
  input  logic                    i_m0_req_we,
  input  logic [`WORD_W-1:0]      i_m0_req_wr_data,
  input  logic [`ADDR_W-1:0]      i_m1_req_addr,
  input  logic [`MEM_COUNT_W-1:0] i_m1_req_count,
  input  logic                    i_m1_req_we,
  input  logic [`WORD_W-1:0]      i_m1_req_wr_data,
  output logic                    o_m0_grant,
  output logic                    o_m0_res_valid,
  output logic [`WORD_W-1:0]      o_m0_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_m0_res_code,
  output logic                    o_m1_grant,
  output logic                    o_m1_res_valid,
  output logic [`WORD_W-1:0]      o_m1_res_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_m1_res_code,
  output logic [`ADDR_W-1:0]      o_req_addr,
  output logic [`MEM_COUNT_W-1:0] o_req_count,
  output logic                    o_req_we,
  output logic [`WORD_W-1:0]      o_req_wr_data,
  input  logic [`WORD_W-1:0]      i_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_res_code
);

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  logic       r_last_grant;
  logic [3:0] r_burst_cnt;
  logic       r_inflight_valid;
  logic       r_inflight_owner;

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;

  assign w_req0 = (i_m0_req_count != `MEM_COUNT_NONE);
  assign w_req1 = (i_m1_req_count != `MEM_COUNT_NONE);

  // Under contention the previous winner keeps the port until its burst
  // allowance is used up, then the other master takes over.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_req0 && w_req1) begin
      if (r_burst_cnt < BURST_MAX) begin
        w_gnt0 = ~r_last_grant;
        w_gnt1 = r_last_grant;
      end else begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end
    end else begin
      w_gnt0 = w_req0;
      w_gnt1 = w_req1;
    end
  end

  assign w_any_gnt  = w_gnt0 | w_gnt1;
  assign o_m0_grant = w_gnt0;
  assign o_m1_grant = w_gnt1;

  always_comb begin
    o_req_addr    = '0;
    o_req_count   = `MEM_COUNT_NONE;
    o_req_we      = 1'b0;
    o_req_wr_data = '0;
    if (w_gnt0) begin
      o_req_addr    = i_m0_req_addr;
      o_req_count   = i_m0_req_count;
      o_req_we      = i_m0_req_we;
      o_req_wr_data = i_m0_req_wr_data;
    end else if (w_gnt1) begin
      o_req_addr    = i_m1_req_addr;
      o_req_count   = i_m1_req_count;
      o_req_we      = i_m1_req_we;
      o_req_wr_data = i_m1_req_wr_data;
    end
  end

  // Reset leaves last_grant on m1 with a spent burst so m0 wins first contention.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_last_grant     <= 1'b1;
      r_burst_cnt      <= BURST_MAX;
      r_inflight_valid <= 1'b0;
      r_inflight_owner <= 1'b0;
    end else if (w_any_gnt) begin
      r_inflight_valid <= 1'b1;
      r_inflight_owner <= w_gnt1;
      if (w_gnt1 == r_last_grant) begin
        if (r_burst_cnt < BURST_MAX) begin
          r_burst_cnt <= r_burst_cnt + 4'd1;
        end
      end else begin
        r_last_grant <= w_gnt1;
        r_burst_cnt  <= 4'd1;
      end
    end else begin
      r_inflight_valid <= 1'b0;
    end
  end

  assign o_m0_res_valid   = r_inflight_valid && !r_inflight_owner;
  assign o_m1_res_valid   = r_inflight_valid && r_inflight_owner;
  assign o_m0_res_rd_data = o_m0_res_valid ? i_res_rd_data : '0;
  assign o_m1_res_rd_data = o_m1_res_valid ? i_res_rd_data : '0;
  assign o_m0_res_code    = o_m0_res_valid ? i_res_code : `MEM_CODE_INVALID;
  assign o_m1_res_code    = o_m1_res_valid ? i_res_code : `MEM_CODE_INVALID;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (BURST_LEN 3 and 1) share stimulus;
// a reference model predicts grants and queues expected responses for a monitor.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 3
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 3'd0
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 3
`endif
`ifndef MEM_CODE_READ
`define MEM_CODE_READ 3'd0
`endif
`ifndef MEM_CODE_WRITE
`define MEM_CODE_WRITE 3'd1
`endif
`ifndef MEM_CODE_MISALIGNED
`define MEM_CODE_MISALIGNED 3'd2
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID 3'd7
`endif

module tb_mem_port_arbiter;
  localparam logic [2:0] C_NONE = `MEM_COUNT_NONE;
  localparam logic [2:0] C_BYTE = 3'd1;
  localparam logic [2:0] C_HALF = 3'd2;
  localparam logic [2:0] C_WORD = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wd = '0, m1_wd = '0;
  logic [2:0]  m0_cnt = C_NONE, m1_cnt = C_NONE;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] res_rd = '0;
  logic [2:0]  res_code = `MEM_CODE_INVALID;

  logic        d_g0 [2], d_g1 [2], d_v0 [2], d_v1 [2], d_we [2];
  logic [31:0] d_rd0 [2], d_rd1 [2], d_addr [2], d_wd [2];
  logic [2:0]  d_c0 [2], d_c1 [2], d_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(.BURST_LEN(g == 0 ? 3 : 1)) u_dut (
      .clk(clk), .aresetn(aresetn),
      .i_m0_req_addr(m0_addr), .i_m0_req_count(m0_cnt),
      .i_m0_req_we(m0_we), .i_m0_req_wr_data(m0_wd),
      .i_m1_req_addr(m1_addr), .i_m1_req_count(m1_cnt),
      .i_m1_req_we(m1_we), .i_m1_req_wr_data(m1_wd),
      .o_m0_grant(d_g0[g]), .o_m0_res_valid(d_v0[g]),
      .o_m0_res_rd_data(d_rd0[g]), .o_m0_res_code(d_c0[g]),
      .o_m1_grant(d_g1[g]), .o_m1_res_valid(d_v1[g]),
      .o_m1_res_rd_data(d_rd1[g]), .o_m1_res_code(d_c1[g]),
      .o_req_addr(d_addr[g]), .o_req_count(d_cnt[g]),
      .o_req_we(d_we[g]), .o_req_wr_data(d_wd[g]),
      .i_res_rd_data(res_rd), .i_res_code(res_code)
    );
  end

  // reference model and scoreboard
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          started = 0;
  int          m_last [2];
  int          m_cnt [2];
  int          blen [2] = '{3, 1};
  int          e_gnt [2];
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_last[i] = 1;
      m_cnt[i]  = blen[i];
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // e_gnt: -1 none, 0 m0, 1 m1
  task automatic model_step(input bit rst_n);
    bit r0, r1;
    int g;
    r0 = (m0_cnt != C_NONE);
    r1 = (m1_cnt != C_NONE);
    if (!rst_n) model_reset();
    for (int i = 0; i < 2; i++) begin
      if (r0 && r1) g = (m_cnt[i] < blen[i]) ? m_last[i] : 1 - m_last[i];
      else if (r0) g = 0;
      else if (r1) g = 1;
      else g = -1;
      e_gnt[i] = g;
      if (rst_n && g >= 0) begin
        if (g == m_last[i]) m_cnt[i] = (m_cnt[i] + 1 > blen[i]) ? blen[i] : m_cnt[i] + 1;
        else begin
          m_last[i] = g;
          m_cnt[i]  = 1;
        end
        if (i == 0) exp_q0.push_back({g[0], 32'(cyc + 1)});
        else        exp_q1.push_back({g[0], 32'(cyc + 1)});
      end
    end
  endtask

  // driver: one call per cycle; res_rd/res_code are the peripheral reply for this cycle
  task automatic drive(input bit rst_n,
                       input logic [2:0] c0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
                       input logic [2:0] c1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                       input logic [31:0] rd, input logic [2:0] code);
    @(posedge clk);
    #1;
    aresetn = rst_n;
    m0_cnt = c0; m0_addr = a0; m0_we = w0; m0_wd = d0;
    m1_cnt = c1; m1_addr = a1; m1_we = w1; m1_wd = d1;
    res_rd = rd; res_code = code;
    cyc++;
    model_step(rst_n);
    started = 1;
  endtask

  task automatic idle(input bit rst_n, input logic [31:0] rd, input logic [2:0] code);
    drive(rst_n, C_NONE, 0, 0, 0, C_NONE, 0, 0, 0, rd, code);
  endtask

  task automatic check_inst(input int i);
    logic [32:0] ent;
    bit ev0, ev1;
    bit have;
    ev0 = 0;
    ev1 = 0;
    have = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    if (have) begin
      ent = (i == 0) ? exp_q0[0] : exp_q1[0];
      if (ent[31:0] == 32'(cyc)) begin
        if (i == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
        if (ent[32]) ev1 = 1; else ev0 = 1;
      end else if (ent[31:0] < 32'(cyc)) begin
        chk("stale_entry", i, ent[31:0], 32'(cyc));
        if (i == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
      end
    end
    chk("m0_grant", i, 32'(d_g0[i]), 32'(e_gnt[i] == 0));
    chk("m1_grant", i, 32'(d_g1[i]), 32'(e_gnt[i] == 1));
    chk("req_count", i, 32'(d_cnt[i]),
        32'(e_gnt[i] == 0 ? m0_cnt : e_gnt[i] == 1 ? m1_cnt : C_NONE));
    chk("req_addr", i, d_addr[i], e_gnt[i] == 0 ? m0_addr : e_gnt[i] == 1 ? m1_addr : 32'd0);
    chk("req_we", i, 32'(d_we[i]), 32'(e_gnt[i] == 0 ? m0_we : e_gnt[i] == 1 ? m1_we : 1'b0));
    chk("req_wr_data", i, d_wd[i], e_gnt[i] == 0 ? m0_wd : e_gnt[i] == 1 ? m1_wd : 32'd0);
    chk("m0_res_valid", i, 32'(d_v0[i]), 32'(ev0));
    chk("m1_res_valid", i, 32'(d_v1[i]), 32'(ev1));
    chk("m0_res_rd_data", i, d_rd0[i], ev0 ? res_rd : 32'd0);
    chk("m1_res_rd_data", i, d_rd1[i], ev1 ? res_rd : 32'd0);
    chk("m0_res_code", i, 32'(d_c0[i]), 32'(ev0 ? res_code : `MEM_CODE_INVALID));
    chk("m1_res_code", i, 32'(d_c1[i]), 32'(ev1 ? res_code : `MEM_CODE_INVALID));
  endtask

  // monitor
  always @(negedge clk) begin
    if (started) begin
      check_inst(0);
      check_inst(1);
    end
  end

  function automatic logic [2:0] rand_count();
    case ($urandom_range(0, 4))
      0: return C_NONE;
      1: return C_BYTE;
      2: return C_HALF;
      default: return C_WORD;
    endcase
  endfunction

  function automatic logic [2:0] rand_code();
    case ($urandom_range(0, 3))
      0: return `MEM_CODE_READ;
      1: return `MEM_CODE_WRITE;
      2: return `MEM_CODE_MISALIGNED;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    model_reset();
    idle(0, 0, `MEM_CODE_INVALID);
    idle(0, 0, `MEM_CODE_INVALID);
    // m0 reads word 0 alone, reply READ next cycle
    drive(1, C_WORD, 32'h0, 0, 0, C_NONE, 0, 0, 0, 32'h0, `MEM_CODE_INVALID);
    idle(1, 32'hDEADBEEF, `MEM_CODE_READ);
    // continuous contention from reset state
    idle(0, 0, `MEM_CODE_INVALID);
    for (int k = 0; k < 8; k++)
      drive(1, C_WORD, 32'h100 + 32'(4 * k), 0, 0, C_WORD, 32'h200 + 32'(4 * k), 1,
            $urandom, $urandom, `MEM_CODE_READ);
    idle(1, $urandom, `MEM_CODE_WRITE);
    // m1 halfword at odd offset, peripheral flags misalignment
    drive(1, C_NONE, 0, 0, 0, C_HALF, 32'h1, 0, 0, 0, `MEM_CODE_READ);
    idle(1, 32'h0, `MEM_CODE_MISALIGNED);
    // reset while m0's access is in flight
    idle(1, 0, `MEM_CODE_READ);
    drive(1, C_WORD, 32'h40, 1, 32'h1234, C_NONE, 0, 0, 0, 0, `MEM_CODE_READ);
    idle(0, 32'hCAFE0000, `MEM_CODE_WRITE);
    idle(1, 32'hCAFE0001, `MEM_CODE_READ);
    drive(1, C_WORD, 32'h50, 0, 0, C_WORD, 32'h60, 0, 0, $urandom, `MEM_CODE_READ);
    drive(1, C_WORD, 32'h54, 0, 0, C_WORD, 32'h64, 0, 0, $urandom, `MEM_CODE_READ);
    // idle gap after an m1 grant
    drive(1, C_NONE, 0, 0, 0, C_BYTE, 32'h70, 1, 32'hAA, $urandom, `MEM_CODE_READ);
    idle(1, $urandom, `MEM_CODE_WRITE);
    idle(1, $urandom, `MEM_CODE_READ);
    drive(1, C_WORD, 32'h80, 0, 0, C_WORD, 32'h90, 0, 0, $urandom, `MEM_CODE_READ);
    drive(1, C_WORD, 32'h84, 0, 0, C_WORD, 32'h94, 0, 0, $urandom, `MEM_CODE_READ);
    // randomized traffic with occasional resets
    for (int k = 0; k < 500; k++) begin
      drive($urandom_range(0, 40) != 0,
            rand_count(), $urandom, 1'($urandom), $urandom,
            rand_count(), $urandom, 1'($urandom), $urandom,
            $urandom, rand_code());
    end
    idle(1, $urandom, rand_code());
    idle(1, $urandom, rand_code());
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q0.size() + exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_responses: got %0d pending expected 0", exp_q0.size() + exp_q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
